sigma_delta_sequencer: RTL and testbench
========================================

Name: sigma_delta_sequencer

Overview:
- Front-end controller for the 2nd-order sigma-delta modulator.
- Accepts PCM samples over a valid/ready stream and holds each sample on the modulator input for exactly OSR modulator ticks.
- Generates the modulator clock-enable strobe at Fclk/CLK_DIV and sequences modulator reset on start and stop.
- Counts underflows, with mute-to-zero on underflow.

Parameters:
- WIDTH, 16: sample width (two's complement); must match modulator WIDTH.
- OSR, 64: modulator ticks per input sample; legal range ≥2.
- CLK_DIV, 1: clk cycles per modulator tick; legal range ≥1.
- CNT_WIDTH, 16: width of underflow counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  level/pulse; begin playback from IDLE
- stop  in  1  level/pulse; end playback after current sample period
- s_valid  in  1  sample valid
- s_ready  out  1  sample ready
- s_data  in  WIDTH  signed sample
- sd_en  out  1  modulator enable strobe
- sd_rst  out  1  modulator reset
- sd_in  out  WIDTH  signed modulator input
- sample_tick  out  1  one-cycle pulse at each sample boundary
- underflow  out  1  one-cycle pulse on underflow
- underflow_cnt  out  CNT_WIDTH  saturating underflow count
- busy  out  1  state != IDLE

Behaviour:
- Reset values: state=IDLE, sd_rst=1, sd_en=0, sd_in=0, s_ready=0, sample_tick=0, underflow=0, underflow_cnt=0, busy=0. All internal registers are cleared, including the div counter, the osr counter and the next-sample buffer. Reset mid-playback drops all samples immediately.
- States and transitions:
  - IDLE: sd_rst=1, sd_in=0; start → PRIME.
  - PRIME: sd_rst=1, s_ready=1. First accepted sample (s_valid&s_ready, cycle t): hold<=s_data, div_cnt=0, osr_cnt=0 → RUN at t+1. stop in PRIME → IDLE (takes priority over accept).
  - RUN: sd_rst=0; accepts into a 1-entry next buffer; stop → FLUSH at the next cycle.
  - FLUSH: sd_rst=0, s_ready=0. Keeps ticking until the next boundary → IDLE. next buffer is discarded.
- Ticking: only in RUN/FLUSH.
  - div_cnt counts 0..CLK_DIV-1 and wraps.
  - sd_en = (RUN|FLUSH) & div_cnt==CLK_DIV-1 (combinational from registers).
  - osr_cnt increments on each sd_en and wraps at OSR-1.
  - Boundary = sd_en & osr_cnt==OSR-1; sample_tick=boundary.
  - First sd_en occurs CLK_DIV cycles after PRIME accept (cycle t+CLK_DIV). Sample period = OSR*CLK_DIV cycles exactly.
- sd_in = hold register; changes only on the cycle after a boundary (or PRIME load).
- s_ready = (PRIME | RUN) & !next_valid.
- Boundary in RUN:
  - next_valid: hold<=next, next_valid<=0.
  - Else if s_valid&s_ready same cycle: hold<=s_data directly, no underflow.
  - Else: hold<=0 (mute), underflow pulses, underflow_cnt++ saturating at all-ones.
- Boundary in FLUSH: no underflow counted; → IDLE.
- Simultaneous stop and boundary in RUN: boundary is processed normally (new hold loaded); FLUSH then plays that sample for a full period.
- start while busy is ignored. stop in IDLE is ignored. start&stop together in IDLE → PRIME, then stop handled in PRIME.
- Widths: no arithmetic on samples; counters sized $clog2(OSR) and $clog2(CLK_DIV) (min 1 bit).

Test Plan:
- (WIDTH=16, OSR=4, CLK_DIV=2) Reset, start, push 0x1000 at t → sd_rst=0 at t+1; sd_en at t+2,t+4,t+6,t+8; sample_tick at t+8; sd_in=0x1000 through t+8.
- Continuous stream 0x1000, 0xF000, 0x0800 with s_valid held → sd_in steps every 8 cycles; underflow_cnt=0; s_ready drops while the next buffer is full.
- Withhold second sample → at first boundary underflow pulse, sd_in=0 next cycle, underflow_cnt=1. Sample arriving exactly on a boundary cycle → loaded, no underflow.
- stop asserted mid-period in RUN → s_ready=0, ticking continues to boundary, then IDLE, sd_rst=1, sd_in=0, busy=0. Buffered next sample is discarded.
- rst asserted mid-RUN → all outputs at reset values next cycle, underflow_cnt=0. stop in PRIME → IDLE with no sd_en ever pulsed.
- CNT_WIDTH=2, four consecutive underflows → underflow_cnt saturates at 3, underflow still pulses each boundary.

Source files
------------

// File: rtl/sigma_delta_sequencer.sv
// Front-end sequencer for the 2nd-order sigma-delta modulator: paces PCM samples
// onto the modulator input, generates its clock-enable and reset, and tracks underflows.
module sigma_delta_sequencer #(
  parameter int WIDTH     = 16,
  parameter int OSR       = 64,
  parameter int CLK_DIV   = 1,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_data,
  output logic                 sd_en,
  output logic                 sd_rst,
  output logic [WIDTH-1:0]     sd_in,
  output logic                 sample_tick,
  output logic                 underflow,
  output logic [CNT_WIDTH-1:0] underflow_cnt,
  output logic                 busy
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int OSR_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [OSR_W-1:0] OSR_LAST = OSR_W'(OSR - 1);

  typedef enum logic [1:0] {S_IDLE, S_PRIME, S_RUN, S_FLUSH} state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [DIV_W-1:0]     r_div_cnt;
  logic [OSR_W-1:0]     r_osr_cnt;
  logic [WIDTH-1:0]     r_hold;
  logic [WIDTH-1:0]     r_next;
  logic                 r_next_valid;
  logic [CNT_WIDTH-1:0] r_ucnt;
  logic                 w_ticking;
  logic                 w_boundary;
  logic                 w_accept;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next_state = S_PRIME;
      S_PRIME: begin
        if (stop)          w_next_state = S_IDLE;
        else if (w_accept) w_next_state = S_RUN;
      end
      S_RUN:   if (stop) w_next_state = S_FLUSH;
      S_FLUSH: if (w_boundary) w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    w_ticking     = (r_state == S_RUN) || (r_state == S_FLUSH);
    sd_en         = w_ticking && (r_div_cnt == DIV_LAST);
    w_boundary    = sd_en && (r_osr_cnt == OSR_LAST);
    s_ready       = ((r_state == S_PRIME) || (r_state == S_RUN)) && !r_next_valid;
    w_accept      = s_valid && s_ready;
    sample_tick   = w_boundary;
    underflow     = (r_state == S_RUN) && w_boundary && !r_next_valid && !w_accept;
    sd_rst        = (r_state == S_IDLE) || (r_state == S_PRIME);
    busy          = (r_state != S_IDLE);
    sd_in         = r_hold;
    underflow_cnt = r_ucnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div_cnt    <= '0;
      r_osr_cnt    <= '0;
      r_hold       <= '0;
      r_next       <= '0;
      r_next_valid <= 1'b0;
      r_ucnt       <= '0;
    end else begin
      // Counters idle at zero outside RUN/FLUSH so the first tick lands CLK_DIV cycles after load.
      if (w_ticking) begin
        r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
        if (sd_en)
          r_osr_cnt <= (r_osr_cnt == OSR_LAST) ? '0 : r_osr_cnt + OSR_W'(1);
      end else begin
        r_div_cnt <= '0;
        r_osr_cnt <= '0;
      end

      unique case (r_state)
        S_PRIME: begin
          if (stop)          r_hold <= '0;
          else if (w_accept) r_hold <= s_data;
        end
        S_RUN: begin
          if (w_boundary) begin
            if (r_next_valid) begin
              r_hold       <= r_next;
              r_next_valid <= 1'b0;
            end else if (w_accept) begin
              r_hold <= s_data;
            end else begin
              r_hold <= '0;
              if (r_ucnt != '1) r_ucnt <= r_ucnt + CNT_WIDTH'(1);
            end
          end else if (w_accept) begin
            r_next       <= s_data;
            r_next_valid <= 1'b1;
          end
        end
        S_FLUSH: begin
          r_next       <= '0;
          r_next_valid <= 1'b0;
          if (w_boundary) r_hold <= '0;
        end
        default: r_hold <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sigma_delta_sequencer.sv
// Bench for sigma_delta_sequencer: cycle model based on elapsed-cycle arithmetic,
// checked every cycle, plus directed hand-computed checks (OSR=4, CLK_DIV=2).
module tb_sigma_delta_sequencer;

  localparam int OSR = 4;
  localparam int DIV = 2;
  localparam int PER = OSR * DIV;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        s_valid = 1'b0;
  logic [15:0] s_data = '0;

  logic        a_ready, a_en, a_rst, a_tick, a_uf, a_busy;
  logic [15:0] a_in, a_cnt;
  logic        b_ready, b_en, b_rst, b_tick, b_uf, b_busy;
  logic [15:0] b_in;
  logic [1:0]  b_cnt;

  sigma_delta_sequencer #(.WIDTH(16), .OSR(OSR), .CLK_DIV(DIV), .CNT_WIDTH(16)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .s_valid(s_valid),
    .s_ready(a_ready), .s_data(s_data), .sd_en(a_en), .sd_rst(a_rst), .sd_in(a_in),
    .sample_tick(a_tick), .underflow(a_uf), .underflow_cnt(a_cnt), .busy(a_busy)
  );

  sigma_delta_sequencer #(.WIDTH(16), .OSR(OSR), .CLK_DIV(DIV), .CNT_WIDTH(2)) dut_b (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .s_valid(s_valid),
    .s_ready(b_ready), .s_data(s_data), .sd_en(b_en), .sd_rst(b_rst), .sd_in(b_in),
    .sample_tick(b_tick), .underflow(b_uf), .underflow_cnt(b_cnt), .busy(b_busy)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: mode 0 idle, 1 prime, 2 run, 3 flush; m_k = cycles since playback began.
  int          m_mode;
  int          m_k;
  logic [15:0] m_hold;
  logic [15:0] m_q[$];
  int          m_u16;
  int          m_u2;
  bit          m_valid = 1'b0;

  task automatic model_reset();
    m_mode = 0; m_k = 0; m_hold = '0; m_q.delete(); m_u16 = 0; m_u2 = 0;
  endtask

  always @(negedge clk) begin : cmp
    bit e_en, e_bnd, e_rdy, e_uf, acc;
    if (!m_valid) begin
      if (rst) begin
        model_reset();
        m_valid = 1'b1;
      end
    end else begin
      e_en  = (m_mode >= 2) && (m_k % DIV == DIV - 1);
      e_bnd = (m_mode >= 2) && ((m_k + 1) % PER == 0);
      e_rdy = (m_mode == 1 || m_mode == 2) && (m_q.size() == 0);
      acc   = s_valid && e_rdy;
      e_uf  = (m_mode == 2) && e_bnd && (m_q.size() == 0) && !acc;

      chk("a_busy",  a_busy,  m_mode != 0);
      chk("a_sdrst", a_rst,   m_mode <= 1);
      chk("a_sdin",  a_in,    m_hold);
      chk("a_sden",  a_en,    e_en);
      chk("a_tick",  a_tick,  e_bnd);
      chk("a_ready", a_ready, e_rdy);
      chk("a_uf",    a_uf,    e_uf);
      chk("a_ucnt",  a_cnt,   m_u16);
      chk("b_busy",  b_busy,  m_mode != 0);
      chk("b_sdin",  b_in,    m_hold);
      chk("b_sden",  b_en,    e_en);
      chk("b_ready", b_ready, e_rdy);
      chk("b_uf",    b_uf,    e_uf);
      chk("b_ucnt",  b_cnt,   m_u2);

      if (rst) begin
        model_reset();
      end else begin
        case (m_mode)
          0: if (start) m_mode = 1;
          1: begin
            if (stop) begin
              m_mode = 0; m_hold = '0;
            end else if (acc) begin
              m_hold = s_data; m_mode = 2; m_k = 0;
            end
          end
          2: begin
            if (e_bnd) begin
              if (m_q.size() != 0) m_hold = m_q.pop_front();
              else if (acc) m_hold = s_data;
              else begin
                m_hold = '0;
                if (m_u16 < 65535) m_u16++;
                if (m_u2 < 3) m_u2++;
              end
            end else if (acc) begin
              m_q.push_back(s_data);
            end
            m_k++;
            if (stop) begin
              m_mode = 3; m_q.delete();
            end
          end
          default: begin
            if (e_bnd) begin
              m_mode = 0; m_hold = '0; m_k = 0;
            end else m_k++;
          end
        endcase
      end
    end
  end

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [15:0] d);
    s_valid = 1'b1;
    s_data  = d;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (a_ready) begin
        next_cyc();
        s_valid = 1'b0;
        return;
      end
      next_cyc();
    end
    total++;
    bad++;
    $display("FAIL send_timeout: sample %0h never accepted", d);
    s_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench did not complete");
    $fatal(1);
  end

  initial begin
    int n_uf;
    bit en_seen;
    bit done;

    rst = 1'b1;
    repeat (3) next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_sdrst", a_rst, 1);
    chk("rst_sden",  a_en, 0);
    chk("rst_sdin",  a_in, 0);
    chk("rst_ready", a_ready, 0);
    chk("rst_busy",  a_busy, 0);
    chk("rst_ucnt",  a_cnt, 0);
    next_cyc();

    stop = 1'b1;
    next_cyc();
    stop = 1'b0;
    @(negedge clk);
    chk("idle_stop_busy", a_busy, 0);
    next_cyc();

    start = 1'b1;
    next_cyc();
    start = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h1000;
    @(negedge clk);
    chk("prime_ready", a_ready, 1);
    chk("prime_sdrst", a_rst, 1);
    next_cyc();
    s_valid = 1'b0;

    // j = cycles after the first accept; sample 0x0800 offered only on the second boundary
    for (int j = 1; j <= 17; j++) begin
      s_valid = (j == 16);
      s_data  = 16'h0800;
      @(negedge clk);
      chk("t1_sden", a_en, (j % 2 == 0));
      chk("t1_tick", a_tick, (j == 8 || j == 16));
      chk("t1_uf",   a_uf, (j == 8));
      if (j == 1)  chk("t1_sdrst_low", a_rst, 0);
      if (j <= 8)  chk("t1_sdin_hold", a_in, 16'h1000);
      if (j == 9)  chk("t1_mute", a_in, 0);
      if (j == 9)  chk("t1_ucnt1", a_cnt, 1);
      if (j == 16) chk("t1_bnd_ready", a_ready, 1);
      if (j == 17) chk("t1_bnd_load", a_in, 16'h0800);
      if (j == 17) chk("t1_bnd_ucnt", a_cnt, 1);
      next_cyc();
    end
    s_valid = 1'b0;

    send(16'hF000);
    @(negedge clk);
    chk("buf_full_ready", a_ready, 0);
    next_cyc();
    send(16'h1234);
    send(16'h0ABC);
    @(negedge clk);
    chk("stream_ucnt", a_cnt, 1);
    next_cyc();

    stop = 1'b1;
    next_cyc();
    stop = 1'b0;
    @(negedge clk);
    chk("flush_ready", a_ready, 0);
    chk("flush_busy", a_busy, 1);
    next_cyc();
    done = 1'b0;
    for (int n = 0; n < 40 && !done; n++) begin
      @(negedge clk);
      if (!a_busy) done = 1'b1;
      else next_cyc();
    end
    if (!done) begin
      total++;
      bad++;
      $display("FAIL flush_timeout: busy never dropped");
    end
    chk("flush_end_sdrst", a_rst, 1);
    chk("flush_end_sdin", a_in, 0);
    next_cyc();

    start = 1'b1;
    next_cyc();
    start = 1'b0;
    send(16'h2222);
    n_uf = 0;
    for (int j = 1; j <= 40; j++) begin
      @(negedge clk);
      if (j == 1) chk("restart_sdin", a_in, 16'h2222);
      n_uf += int'(a_uf);
      next_cyc();
    end
    chk("sat_uf_pulses", n_uf, 5);
    chk("sat_b_cnt", b_cnt, 3);
    chk("sat_a_cnt", a_cnt, 6);

    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_sdrst", a_rst, 1);
    chk("midrst_sden", a_en, 0);
    chk("midrst_sdin", a_in, 0);
    chk("midrst_ready", a_ready, 0);
    chk("midrst_busy", a_busy, 0);
    chk("midrst_acnt", a_cnt, 0);
    chk("midrst_bcnt", b_cnt, 0);
    next_cyc();

    start = 1'b1;
    stop  = 1'b1;
    next_cyc();
    start = 1'b0;
    s_valid = 1'b1;
    s_data  = 16'h5555;
    @(negedge clk);
    chk("ss_prime_busy", a_busy, 1);
    next_cyc();
    stop = 1'b0;
    s_valid = 1'b0;
    en_seen = 1'b0;
    for (int j = 0; j < 12; j++) begin
      @(negedge clk);
      en_seen |= a_en;
      next_cyc();
    end
    chk("ss_no_sden", en_seen, 0);
    @(negedge clk);
    chk("ss_idle_busy", a_busy, 0);
    chk("ss_idle_sdin", a_in, 0);
    next_cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
